vdc_crtc_timing: RTL

VDC_CRTC_TIMING -- requirements
Module: vdc_crtc_timing

---
 rtl/vdc_pkg.sv | 22 ++
 rtl/vdc_sync_pulse.sv | 44 ++++
 rtl/vdc_crtc_timing.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/vdc_pkg.sv
// Shared types and constants for the CRTC timing generator: vertical state,
// counter widths and the sync-width decode.
package vdc_pkg;

  localparam int unsigned COL_W  = 8;
  localparam int unsigned ROW_W  = 8;
  localparam int unsigned LINE_W = 5;
  localparam int unsigned PIX_W  = 4;
  localparam int unsigned SW_W   = 5;

  typedef enum logic [1:0] {
    VS_ACTIVE    = 2'd0,
    VS_ADJUST    = 2'd1,
    VS_FRAME_END = 2'd2
  } vstate_e;

  // A programmed width of 0 selects the maximum of 16.
  function automatic logic [SW_W-1:0] sync_width(input logic [3:0] w);
    return (w == 4'd0) ? SW_W'(16) : {1'b0, w};
  endfunction

endpackage

// File: rtl/vdc_sync_pulse.sv
// One sync pulse: a start strobe raises the output and loads a width counter
// that is decremented on each step strobe; the output falls on the last step.
module vdc_sync_pulse
  import vdc_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            start,
  input  logic            step,
  input  logic [SW_W-1:0] width,
  output logic            pulse
);

  logic [SW_W-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    if (start) begin
      cnt_d   = width;
      pulse_d = 1'b1;
    end else if (step && (cnt_q != '0)) begin
      cnt_d = cnt_q - SW_W'(1);
      if (cnt_q == SW_W'(1)) begin
        pulse_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else if (enable) begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/vdc_crtc_timing.sv
// CRTC raster timing: pixel/col/line/row counters, vertical adjust and frame-end
// sequencing, display enables and h/v sync. Optional VDC_INTERLACE_EN adds field.
module vdc_crtc_timing
  import vdc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] reg_ht,
  input  logic [7:0] reg_hd,
  input  logic [7:0] reg_hp,
  input  logic [3:0] reg_hw,
  input  logic [3:0] reg_vw,
  input  logic [7:0] reg_vt,
  input  logic [7:0] reg_vd,
  input  logic [7:0] reg_vp,
  input  logic [4:0] reg_va,
  input  logic [4:0] reg_ctv,
  input  logic [3:0] reg_cth,
  input  logic [1:0] reg_im,
  output logic       hsync,
  output logic       vsync,
  output logic       hdisp,
  output logic       vdisp,
  output logic       line_start,
  output logic       frame_start,
  output logic       field,
  output logic [7:0] col,
  output logic [7:0] row,
  output logic [4:0] line,
  output logic [3:0] pixel
);

  vstate_e           st_q, st_d;
  logic [PIX_W-1:0]  pixel_q, pixel_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              hdisp_q, hdisp_d;
  logic              vdisp_q, vdisp_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic              field_q, field_d;

  logic              pix_wrap, col_wrap;
  logic              col_adv, new_line;
  logic              hstart, vstart, vstep;
  logic              vrow_hit, mid_hit, odd_field;
  logic [SW_W-1:0]   hw_dec, vw_dec;
  logic              unused_im;

  assign unused_im = ^reg_im;
  assign hw_dec    = sync_width(reg_hw);
  assign vw_dec    = sync_width(reg_vw);

  always_comb begin
    st_d     = st_q;
    pixel_d  = pixel_q;
    col_d    = col_q;
    line_d   = line_q;
    row_d    = row_q;
    col_adv  = 1'b0;
    new_line = 1'b0;
    pix_wrap = (pixel_q >= reg_cth);
    col_wrap = (col_q >= reg_ht);

    if (st_q == VS_FRAME_END) begin
      st_d     = VS_ACTIVE;
      pixel_d  = '0;
      col_d    = '0;
      line_d   = '0;
      row_d    = '0;
      col_adv  = 1'b1;
      new_line = 1'b1;
    end else if (!pix_wrap) begin
      pixel_d = pixel_q + 4'd1;
    end else if (!col_wrap) begin
      pixel_d = '0;
      col_d   = col_q + 8'd1;
      col_adv = 1'b1;
    end else begin
      if (st_q == VS_ADJUST) begin
        if (({1'b0, line_q} + 6'd1) >= {1'b0, reg_va}) begin
          st_d = VS_FRAME_END;
        end else begin
          line_d = line_q + 5'd1;
        end
      end else if (line_q < reg_ctv) begin
        line_d = line_q + 5'd1;
      end else if (row_q < reg_vt) begin
        row_d  = row_q + 8'd1;
        line_d = '0;
      end else if (reg_va != '0) begin
        st_d   = VS_ADJUST;
        row_d  = row_q + 8'd1;
        line_d = '0;
      end else begin
        st_d = VS_FRAME_END;
      end
      // Entering FRAME_END holds every counter; the clear happens on its one cycle.
      if (st_d != VS_FRAME_END) begin
        pixel_d  = '0;
        col_d    = '0;
        col_adv  = 1'b1;
        new_line = 1'b1;
      end
    end
  end

  // Every decoded output is built from next-state counters, so it lines up with
  // the counter outputs it describes.
  always_comb begin
    hdisp_d       = (st_d == VS_ACTIVE) && (col_d < reg_hd);
    vdisp_d       = (st_d == VS_ACTIVE) && (row_d < reg_vd);
    line_start_d  = new_line;
    frame_start_d = (st_q == VS_FRAME_END);
    hstart        = col_adv && (col_d == reg_hp) && (reg_hp <= reg_ht);
    vrow_hit      = (st_d == VS_ACTIVE) && (line_d == '0) && (row_d == reg_vp) &&
                    (reg_vp <= reg_vt);
    mid_hit       = col_adv && (col_d == (reg_ht >> 1));
`ifdef VDC_INTERLACE_EN
    odd_field     = reg_im[0] & field_q;
    field_d       = frame_start_d ? ~field_q : field_q;
`else
    odd_field     = 1'b0;
    field_d       = 1'b0;
`endif
    vstart        = odd_field ? (vrow_hit && mid_hit) : (vrow_hit && new_line);
    vstep         = odd_field ? mid_hit : new_line;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q          <= VS_ACTIVE;
      pixel_q       <= '0;
      col_q         <= '0;
      line_q        <= '0;
      row_q         <= '0;
      hdisp_q       <= 1'b0;
      vdisp_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      field_q       <= 1'b0;
    end else if (enable) begin
      st_q          <= st_d;
      pixel_q       <= pixel_d;
      col_q         <= col_d;
      line_q        <= line_d;
      row_q         <= row_d;
      hdisp_q       <= hdisp_d;
      vdisp_q       <= vdisp_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      field_q       <= field_d;
    end
  end

  vdc_sync_pulse u_hsync (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .start   (hstart),
    .step    (col_adv),
    .width   (hw_dec),
    .pulse   (hsync)
  );

  vdc_sync_pulse u_vsync (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .start   (vstart),
    .step    (vstep),
    .width   (vw_dec),
    .pulse   (vsync)
  );

  assign hdisp       = hdisp_q;
  assign vdisp       = vdisp_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign field       = field_q;
  assign col         = col_q;
  assign row         = row_q;
  assign line        = line_q;
  assign pixel       = pixel_q;

endmodule
